// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 8-bit bus driver: command bytes, bus payload,
// FSM encoding and the long-execution command predicate.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

    localparam logic [1:0] INIT_LAST_IDX = 2'd3;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_EN_HI     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_IDLE      = 3'd5
    } lcd_state_e;

    // Clear and Return Home need the long execution wait; everything else is short.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_ctr.sv
// Loadable down-counter shared by every timed phase of the LCD bus driver.
// done_c_o is high while the count is zero; the counter parks at zero.
module lcd_delay_ctr #(
    parameter int unsigned   W       = 20,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_c_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_c_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit write-only bus driver: runs the power-on init sequence, then accepts one
// byte per valid/ready handshake and strobes it onto the bus with timed setup/EN/exec waits.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       In_Valid,
    output logic       In_Ready,
    input  logic       In_RS,
    input  logic [7:0] In_Data,
    output logic       Init_Done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
);

    if (T_PWR < 1 || T_SETUP < 1 || T_EN < 1 || T_CMD < 1 || T_CLR < 1 ||
        T_PWR > (1 << CNT_W) || T_CLR > (1 << CNT_W)) begin : g_param_check
        $error("lcd_bus_driver: timing parameters must be >= 1 and fit in CNT_W bits");
    end

    lcd_state_e       state_q, state_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic             init_done_q, init_done_d;
    logic             ready_q, ready_d;
    logic             en_q, en_d;
    lcd_byte_t        bus_q, bus_d;
    logic [7:0]       rom_byte;
    logic             ctr_load;
    logic [CNT_W-1:0] ctr_val;
    logic             ctr_done;
    logic             accept;

    // ready_q is only ever set while sitting in IDLE
    assign accept = ready_q & In_Valid;

    // Init ROM
    always_comb begin
        rom_byte = LCD_FUNC_8B2L;
        case (init_idx_q)
            2'd0:    rom_byte = LCD_FUNC_8B2L;
            2'd1:    rom_byte = LCD_DISP_ON;
            2'd2:    rom_byte = LCD_CLEAR;
            default: rom_byte = LCD_ENTRY_INC;
        endcase
    end

    // Reset preloads T_PWR-1 so PWR_WAIT lasts T_PWR cycles without a separate load
    lcd_delay_ctr #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(T_PWR - 1))
    ) u_delay_ctr (
        .clk_i      (Clock),
        .rst_ni     (Reset_n),
        .load_i     (ctr_load),
        .load_val_i (ctr_val),
        .done_c_o   (ctr_done)
    );

    // Next-state, counter reloads and registered-output next values
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        bus_d       = bus_q;
        ctr_load    = 1'b0;
        ctr_val     = '0;

        unique case (state_q)
            ST_PWR_WAIT: begin
                if (ctr_done) begin
                    state_d  = ST_INIT_LOAD;
                    ctr_load = 1'b1;
                end
            end
            ST_INIT_LOAD: begin
                bus_d    = '{rs: 1'b0, data: rom_byte};
                state_d  = ST_SETUP;
                ctr_load = 1'b1;
                ctr_val  = CNT_W'(T_SETUP - 1);
            end
            ST_IDLE: begin
                if (accept) begin
                    bus_d    = '{rs: In_RS, data: In_Data};
                    state_d  = ST_SETUP;
                    ctr_load = 1'b1;
                    ctr_val  = CNT_W'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (ctr_done) begin
                    state_d  = ST_EN_HI;
                    ctr_load = 1'b1;
                    ctr_val  = CNT_W'(T_EN - 1);
                end
            end
            ST_EN_HI: begin
                if (ctr_done) begin
                    state_d  = ST_EXEC;
                    ctr_load = 1'b1;
                    ctr_val  = is_long_cmd(bus_q.rs, bus_q.data) ? CNT_W'(T_CLR - 1)
                                                                 : CNT_W'(T_CMD - 1);
                end
            end
            ST_EXEC: begin
                if (ctr_done) begin
                    ctr_load = 1'b1;
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (init_idx_q == INIT_LAST_IDX) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d    = ST_INIT_LOAD;
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        en_d    = (state_d == ST_EN_HI);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= ST_PWR_WAIT;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            en_q        <= 1'b0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            en_q        <= en_d;
            bus_q       <= bus_d;
        end
    end

    assign In_Ready  = ready_q;
    assign Init_Done = init_done_q;
    assign LCD_RS    = bus_q.rs;
    assign LCD_RW    = 1'b0;
    assign LCD_EN    = en_q;
    assign LCD_DATA  = bus_q.data;

endmodule
